// File: rtl/nibble_parity_pkg.sv
// Shared FSM state encoding and frame constants for the nibble parity receiver.
package nibble_parity_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam int   DATA_BITS = 4;
   localparam int   IDX_W     = $clog2(DATA_BITS);
   localparam logic START     = 1'b0;
   localparam logic STOP      = 1'b1;

endpackage

// File: rtl/nibble_parity_rx_parity4.sv
// Even-parity generator over one nibble; identical to the transmit-side XOR tree.
module parity4
   import nibble_parity_pkg::*;
(
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_par
);

   assign o_par = ^i_data;

endmodule

// File: rtl/nibble_parity_rx.sv
// Serial nibble receiver: start, d0..d3 LSB first, even parity, stop; ready/valid output.
// Error counter is built only when NIBBLE_PARITY_RX_ERRCNT_EN is defined; otherwise err_cnt is 0.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a start bit on a tick
// S_DATA   | shifting in d0..d3, r_idx selects the bit
// S_PARITY | sampling the parity bit, latching the parity error
// S_STOP   | sampling the stop bit; load output or flag framing error
module nibble_parity_rx
   import nibble_parity_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_tick,
   input  logic             sin,
   input  logic             rdy,
   output logic [3:0]       dout,
   output logic             vld,
   output logic             par_err,
   output logic             frm_err,
   output logic             ovr,
   output logic [CNT_W-1:0] err_cnt
);

   state_t                 r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_perr;
   logic [DATA_BITS-1:0]   r_dout;
   logic                   r_vld;
   logic                   r_par_err;
   logic                   r_frm_err;
   logic                   r_ovr;

   logic                   w_par;
   logic                   w_load;
   logic                   w_ferr;

   parity4 u_parity4 (
      .i_data (r_shift),
      .o_par  (w_par)
   );

   assign w_load = bit_tick && (r_state == S_STOP) && (sin == STOP);
   assign w_ferr = bit_tick && (r_state == S_STOP) && (sin == START);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_shift   <= '0;
         r_perr    <= 1'b0;
         r_dout    <= '0;
         r_vld     <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_frm_err <= w_ferr;

         if (bit_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (sin == START) begin
                     r_state <= S_DATA;
                     r_idx   <= '0;
                  end
               end
               S_DATA: begin
                  r_shift[r_idx] <= sin;
                  if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
               S_PARITY: begin
                  r_perr  <= w_par ^ sin;
                  r_state <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end

         // A new load wins over acceptance; the old nibble counts as consumed only if rdy was high.
         if (w_load) begin
            r_dout    <= r_shift;
            r_par_err <= r_perr;
            r_vld     <= 1'b1;
            if (r_vld && !rdy) begin
               r_ovr <= 1'b1;
            end
         end else if (r_vld && rdy) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign dout    = r_dout;
   assign vld     = r_vld;
   assign par_err = r_par_err;
   assign frm_err = r_frm_err;
   assign ovr     = r_ovr;

`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_err_inc;

   assign w_err_inc = (w_load && r_perr) || w_ferr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_err_inc && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Bench for nibble_parity_rx: frame table, hand-written corner sequences, random traffic vs a frame-level model.
module tb_nibble_parity_rx;

`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, bit_tick, sin, rdy;
   logic [3:0] dout, dout2;
   logic       vld, par_err, frm_err, ovr;
   logic       vld2, par_err2, frm_err2, ovr2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nibble_parity_rx #(.CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .bit_tick(bit_tick), .sin(sin), .rdy(rdy),
      .dout(dout), .vld(vld), .par_err(par_err), .frm_err(frm_err),
      .ovr(ovr), .err_cnt(err_cnt)
   );

   nibble_parity_rx #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .bit_tick(bit_tick), .sin(sin), .rdy(rdy),
      .dout(dout2), .vld(vld2), .par_err(par_err2), .frm_err(frm_err2),
      .ovr(ovr2), .err_cnt(err_cnt2)
   );

   // Frame-level reference: position within frame, captured bits, output registers.
   int         m_pos;
   logic       m_bits [0:4];
   logic [3:0] m_dout;
   logic       m_vld, m_perr, m_frm, m_ovr;
   int         m_cnt8, m_cnt2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bump();
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
   endtask

   task automatic model_update();
      logic       load, frm;
      logic [3:0] d;
      load = 1'b0;
      frm  = 1'b0;
      if (rst) begin
         m_pos = -1; m_dout = 4'h0; m_vld = 1'b0; m_perr = 1'b0;
         m_frm = 1'b0; m_ovr = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
         return;
      end
      if (bit_tick) begin
         if (m_pos < 0) begin
            if (sin == 1'b0) m_pos = 0;
         end else if (m_pos < 5) begin
            m_bits[m_pos] = sin;
            m_pos++;
         end else begin
            if (sin) load = 1'b1;
            else     frm  = 1'b1;
            m_pos = -1;
         end
      end
      if (load) begin
         d = {m_bits[3], m_bits[2], m_bits[1], m_bits[0]};
         if (m_vld && !rdy) m_ovr = 1'b1;
         m_dout = d;
         m_perr = ($countones({d, m_bits[4]}) % 2) == 1;
         m_vld  = 1'b1;
         if (m_perr) bump();
      end else if (m_vld && rdy) begin
         m_vld = 1'b0;
      end
      m_frm = frm;
      if (frm) bump();
   endtask

   task automatic step(input logic t, input logic s, input logic r, input logic rs);
      bit_tick = t; sin = s; rdy = r; rst = rs;
      @(posedge clk);
      model_update();
      #1;
      chk("cycle_w8", {dout, vld, par_err, frm_err, ovr, err_cnt},
          {m_dout, m_vld, m_perr, m_frm, m_ovr, (EN ? 8'(m_cnt8) : 8'd0)});
      chk("cycle_w2", {dout2, vld2, par_err2, frm_err2, ovr2, err_cnt2},
          {m_dout, m_vld, m_perr, m_frm, m_ovr, (EN ? 2'(m_cnt2) : 2'd0)});
   endtask

   // Each bit: two hold cycles then its tick; r_last is rdy during the stop bit.
   task automatic send_frame(input logic [3:0] d, input logic p, input logic sb,
                             input logic r, input logic r_last);
      logic [6:0] fr;
      fr = {sb, p, d, 1'b0};
      for (int i = 0; i < 7; i++) begin
         step(1'b0, fr[i], r, 1'b0);
         step(1'b0, fr[i], r, 1'b0);
         step(1'b1, fr[i], (i == 6) ? r_last : r, 1'b0);
      end
   endtask

   typedef struct {
      logic [3:0] d;
      logic       p;
      logic       sb;
      logic [3:0] e_dout;
      logic       e_vld;
      logic       e_perr;
      logic       e_frm;
      int         e_cnt;
   } vec_t;

   vec_t tbl [6];

   initial begin
      rst = 1'b1; bit_tick = 1'b0; sin = 1'b1; rdy = 1'b1;

      tbl[0] = '{d:4'hD, p:1'b1, sb:1'b1, e_dout:4'hD, e_vld:1'b1, e_perr:1'b0, e_frm:1'b0, e_cnt:0};
      tbl[1] = '{d:4'hD, p:1'b0, sb:1'b1, e_dout:4'hD, e_vld:1'b1, e_perr:1'b1, e_frm:1'b0, e_cnt:1};
      tbl[2] = '{d:4'h5, p:1'b0, sb:1'b0, e_dout:4'hD, e_vld:1'b0, e_perr:1'b1, e_frm:1'b1, e_cnt:2};
      tbl[3] = '{d:4'h6, p:1'b0, sb:1'b1, e_dout:4'h6, e_vld:1'b1, e_perr:1'b0, e_frm:1'b0, e_cnt:2};
      tbl[4] = '{d:4'h7, p:1'b1, sb:1'b1, e_dout:4'h7, e_vld:1'b1, e_perr:1'b0, e_frm:1'b0, e_cnt:2};
      tbl[5] = '{d:4'h0, p:1'b1, sb:1'b1, e_dout:4'h0, e_vld:1'b1, e_perr:1'b1, e_frm:1'b0, e_cnt:3};

      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("reset_outputs", {dout, vld, par_err, frm_err, ovr, err_cnt}, 16'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].d, tbl[i].p, tbl[i].sb, 1'b1, 1'b1);
         chk("tbl_dout", dout, tbl[i].e_dout);
         chk("tbl_vld", vld, tbl[i].e_vld);
         chk("tbl_par_err", par_err, tbl[i].e_perr);
         chk("tbl_frm_err", frm_err, tbl[i].e_frm);
         chk("tbl_err_cnt", err_cnt, EN ? 8'(tbl[i].e_cnt) : 8'd0);
         step(1'b0, 1'b1, 1'b1, 1'b0);
         chk("tbl_vld_pulse", vld, 1'b0);
         chk("tbl_frm_pulse", frm_err, 1'b0);
      end

      // Overrun with consumer stalled
      send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ovr_first_vld", vld, 1'b1);
      chk("ovr_first_ovr", ovr, 1'b0);
      send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ovr_dout", dout, 4'hA);
      chk("ovr_vld", vld, 1'b1);
      chk("ovr_flag", ovr, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ovr_vld_clear", vld, 1'b0);
      chk("ovr_sticky", ovr, 1'b1);

      // Reset after the d1 tick of a 4'h6 frame, then a clean 4'h6 frame
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_ovr", ovr, 1'b0);
      send_frame(4'h6, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_dout", dout, 4'h6);
      chk("mid_rst_vld", vld, 1'b1);
      chk("mid_rst_par_err", par_err, 1'b0);
      chk("mid_rst_err_cnt", err_cnt, 8'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);

      // Load coinciding with acceptance: no overrun
      send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("coinc_dout", dout, 4'h5);
      chk("coinc_vld", vld, 1'b1);
      chk("coinc_ovr", ovr, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("coinc_vld_clear", vld, 1'b0);

      // Saturation of the narrow counter
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         send_frame(4'hD, 1'b0, 1'b1, 1'b1, 1'b1);
      end
      chk("sat_cnt_w2", err_cnt2, EN ? 2'd3 : 2'd0);
      chk("sat_cnt_w8", err_cnt, EN ? 8'd5 : 8'd0);

      // Random well-formed and malformed frames
      for (int k = 0; k < 150; k++) begin
         send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      end

      // Random line activity including occasional resets
      for (int k = 0; k < 4000; k++) begin
         step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
